// File: rtl/wb_pkg.sv
// Shared widths, write-entry payload and r0 helper for the writeback path.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 16;

  localparam logic [REG_ADDR_W-1:0] R0_IDX = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic is_r0(input logic [REG_ADDR_W-1:0] rd);
    return rd == R0_IDX;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO: power-of-two depth, extra pointer bit separates full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t     mem_q [DEPTH];
  logic          push_ok, pop_ok;

  // Status flags and guarded pointer advance
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while not between the pointers
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write master: ALU-first arbitration with load-starvation override,
// load-return buffering and a pending-load scoreboard for decode.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_Rd,
  output logic [DATA_W-1:0]     write_data,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]         starve_q, starve_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  wb_entry_t fifo_head, push_entry, sel_entry;
  logic      fifo_full, fifo_empty;
  logic      force_ld, alu_take, ld_pop, ld_push;

  // Arbitration: forced load drain, else ALU, else opportunistic load pop
  always_comb begin
    force_ld        = (starve_q == STARVE_LIM) && !fifo_empty;
    alu_take        = !rst && !force_ld && alu_valid;
    ld_pop          = !rst && !fifo_empty && (force_ld || !alu_valid);
    ld_push         = ld_valid && !rst && !fifo_full;
    push_entry.rd   = ld_rd;
    push_entry.data = ld_data;
    if (alu_take) begin
      sel_entry.rd   = alu_rd;
      sel_entry.data = alu_data;
    end else begin
      sel_entry = fifo_head;
    end
  end

  assign alu_ready = !rst && !force_ld;
  assign ld_ready  = !rst && !fifo_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ld_push),
    .push_entry (push_entry),
    .pop        (ld_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Starvation counter: counts cycles a waiting load loses, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (ld_pop || fifo_empty)       starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
  end

  // Scoreboard: clear on load commit, set on issue (set wins on collision)
  always_comb begin
    busy_d = busy_q;
    if (ld_pop) busy_d[fifo_head.rd] = 1'b0;
    if (ld_issue && !(ZERO_REG && is_r0(ld_issue_rd))) busy_d[ld_issue_rd] = 1'b1;
  end

  // Write port next value; address/data hold when nothing is written
  always_comb begin
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if ((alu_take || ld_pop) && !(ZERO_REG && is_r0(sel_entry.rd))) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = sel_entry.rd;
      wr_data_d = sel_entry.data;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign write_en   = wr_en_q;
  assign write_Rd   = wr_rd_q;
  assign write_data = wr_data_q;
  assign busy       = busy_q;

endmodule
